reg_access_arbiter: RTL and testbench
=====================================

# reg_access_arbiter

Arbitrates the SD host register bank's single access port between the CPU bus interface and the internal SD core (command/DMA engines). Each requester issues byte, half-word or word reads and writes with a req/ack handshake. The arbiter selects one requester, aligns data and byte enables onto the 32-bit bank port, checks alignment, and returns aligned read data with a one-cycle acknowledge. It sits between the CPU communication front end and the register file.

## Interface
- ADDR_WIDTH, 8, byte address width of the register map (256 bytes)
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset; synchronous, active-low
- cpu_req / core_req  in  1  access request; held until the matching ack
- cpu_wr / core_wr  in  1  1 = write, 0 = read
- cpu_addr / core_addr  in  ADDR_WIDTH  byte address
- cpu_size / core_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_wdata / core_wdata  in  32  write data, right-justified
- cpu_rdata / core_rdata  out  32  read data, right-justified, zero-extended, registered
- cpu_ack / core_ack  out  1  one-cycle completion pulse
- cpu_err / core_err  out  1  valid with ack; 1 = access rejected
- rf_en  out  1  bank access strobe
- rf_wr  out  1  bank write enable (qualified by rf_en)
- rf_addr  out  ADDR_WIDTH-2  word address
- rf_be  out  4  byte enables
- rf_wdata  out  32  lane-aligned write data
- rf_rdata  in  32  bank read data, valid one cycle after rf_en

## Operation
- FSM states: IDLE, ISSUE, DATA, DONE. Transitions IDLE->ISSUE (any req), ISSUE->DATA, DATA->DONE, DONE->IDLE, all unconditional except leaving IDLE.
- IDLE: if any req is high, pick a winner, latch its wr/addr/size/wdata and the winner id. Later changes to the requester's inputs are ignored.
- Alignment check at latch:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
- ISSUE:
  - rf_en=1 unless the access is in error.
  - rf_addr=addr[ADDR_WIDTH-1:2].
  - rf_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<(2*addr[1]); word = 4'b1111.
  - rf_wdata = wdata<<(8*addr[1:0]).
- DATA: on a non-error read, the winner's rdata register is loaded with (rf_rdata>>(8*addr[1:0])) masked to size. Writes and errors leave rdata unchanged.
- DONE: the winner's ack=1 and err=error flag for exactly one cycle. The loser's outputs are untouched.
- rdata holds its value until that requester's next successful read.
- Dropping req before ack does not abort: the transaction completes and ack is still pulsed.
- Keeping req high through ack means a new request, re-arbitrated in the following IDLE cycle.
- Arbitration when both req are high in IDLE: CPU wins (fixed priority) unless round-robin is compiled in (see Configuration).

## Timing
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - rf_en, rf_wr, rf_addr, rf_be, rf_wdata = 0.
  - cpu_ack, core_ack, cpu_err, core_err = 0.
  - cpu_rdata, core_rdata = 0.
  - Round-robin pointer = core (last grant), so the CPU wins first.
- Reset mid-operation: the transaction is abandoned and no ack is issued. A write already strobed in ISSUE stays committed.
- Cycle t, req sampled in IDLE:
  - t+1 ISSUE: rf_en.
  - t+2 DATA: rf_rdata captured.
  - t+3 DONE: ack/err high, rdata valid.
  - t+4 IDLE: next arbitration.
- Error accesses have the same t+3 latency, with rf_en held 0.
- Throughput: one access per 4 cycles. rf_en is never asserted in two consecutive cycles.
- All outputs are registered or decoded from the registered state and latched fields. There are no combinational paths from req to the rf_* outputs.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-grant pointer is updated on every grant.
  - On contention, the requester not granted last wins.
  - A lone requester always wins regardless of the pointer.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed CPU priority; the pointer logic is absent.
  - The core can starve under continuous CPU traffic. This is accepted.

## Test plan
- Reset, then CPU word write addr 0x10, data 0xDEADBEEF:
  - rf_en at t+1 with rf_addr=0x04, rf_be=4'b1111, rf_wdata=0xDEADBEEF.
  - cpu_ack=1, cpu_err=0 at t+3; core outputs stay 0.
- Core byte read addr 0x2E, bank returns 0x11223344 → core_rdata=0x00000022 with core_ack at t+3; rf_be=4'b0100.
- CPU half write addr 0x06, data 0xABCD → rf_be=4'b1100, rf_wdata=0xABCD0000.
- CPU word read addr 0x02 → no rf_en; cpu_ack=1, cpu_err=1 at t+3; cpu_rdata unchanged.
- Both requests held high for 8 cycles:
  - Fixed priority: two CPU acks, zero core acks.
  - With ARB_ROUND_ROBIN_EN: acks alternate CPU, core.
- rst_n low at t+2 of a read → no ack, all outputs 0 next cycle; a new CPU read after release completes normally.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
//   Shares the SD host register bank's single access port between the CPU
//   bus interface and the internal SD core. Each requester issues byte,
//   half-word or word accesses with a req/ack handshake. One access takes
//   four cycles: IDLE (arbitrate and latch), ISSUE (bank strobe), DATA
//   (capture read data) and DONE (one-cycle ack/err to the winner).
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration using a 1-bit last-grant pointer
//     undefined -> fixed priority, CPU wins on contention
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   cpu_* / core_*           requester side: req, wr, addr, size, wdata in;
//                            rdata (registered), ack, err out
//   rf_en, rf_wr, rf_addr,   bank side: strobe, write enable, word address,
//   rf_be, rf_wdata          byte enables, lane-aligned write data
//   rf_rdata                 bank read data, valid one cycle after rf_en
`timescale 1ns/1ps

module reg_access_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [1:0]            cpu_size,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,

  input  logic                  core_req,
  input  logic                  core_wr,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [1:0]            core_size,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_ack,
  output logic                  core_err,

  output logic                  rf_en,
  output logic                  rf_wr,
  output logic [ADDR_WIDTH-3:0] rf_addr,
  output logic [3:0]            rf_be,
  output logic [31:0]           rf_wdata,
  input  logic [31:0]           rf_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t state;
  state_t state_next;

  // Fields of the access in flight, captured when leaving IDLE.
  logic                  lat_wr;
  logic                  lat_err;
  logic                  lat_core;   // 0 = CPU owns the access, 1 = core
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_size;
  logic [31:0]           lat_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic any_req;
  logic grant_core;

  assign any_req = cpu_req | core_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = core was granted last. Resets to core so the CPU wins the first tie.
  logic last_core;

  // On a tie the requester that was not granted last wins; a lone requester
  // always wins.
  assign grant_core = core_req & (~cpu_req | ~last_core);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_core <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_core <= grant_core;
    end
  end
`else
  assign grant_core = core_req & ~cpu_req;
`endif

  // Winner's request fields.
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [31:0]           sel_wdata;
  logic                  sel_err;

  always_comb begin
    sel_wr    = grant_core ? core_wr    : cpu_wr;
    sel_addr  = grant_core ? core_addr  : cpu_addr;
    sel_size  = grant_core ? core_size  : cpu_size;
    sel_wdata = grant_core ? core_wdata : cpu_wdata;
    // Misaligned half/word accesses and the reserved size code are rejected.
    sel_err   = (sel_size == 2'b11) ||
                (sel_size == SIZE_HALF && sel_addr[0]) ||
                (sel_size == SIZE_WORD && sel_addr[1:0] != 2'b00);
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = DATA;
      DATA:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      lat_core  <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= 2'b00;
      lat_wdata <= 32'h0;
    end else if (state == IDLE && any_req) begin
      lat_wr    <= sel_wr;
      lat_err   <= sel_err;
      lat_core  <= grant_core;
      lat_addr  <= sel_addr;
      lat_size  <= sel_size;
      lat_wdata <= sel_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank port: decoded from state and latched fields only, so nothing from
  // the request inputs reaches rf_* in the same cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] lane;
  logic [4:0] lane_shift;
  logic       issue_active;
  logic [3:0] be_dec;

  assign lane         = lat_addr[1:0];
  assign lane_shift   = {lane, 3'b000};
  assign issue_active = (state == ISSUE) && !lat_err;

  always_comb begin
    be_dec = 4'b0000;
    case (lat_size)
      SIZE_BYTE: be_dec = 4'b0001 << lane;
      SIZE_HALF: be_dec = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be_dec = 4'b1111;
      default:   be_dec = 4'b0000;
    endcase
  end

  always_comb begin
    rf_en    = issue_active;
    rf_wr    = issue_active & lat_wr;
    rf_addr  = issue_active ? lat_addr[ADDR_WIDTH-1:2] : '0;
    rf_be    = issue_active ? be_dec : 4'b0000;
    rf_wdata = issue_active ? (lat_wdata << lane_shift) : 32'h0;
  end

  // ---------------------------------------------------------------------------
  // Read data return
  // ---------------------------------------------------------------------------
  logic [31:0] rd_shifted;
  logic [31:0] rd_aligned;

  assign rd_shifted = rf_rdata >> lane_shift;

  always_comb begin
    rd_aligned = rd_shifted;
    case (lat_size)
      SIZE_BYTE: rd_aligned = {24'h0, rd_shifted[7:0]};
      SIZE_HALF: rd_aligned = {16'h0, rd_shifted[15:0]};
      default:   rd_aligned = rd_shifted;
    endcase
  end

  // Each requester's rdata holds until its next successful read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rdata  <= 32'h0;
      core_rdata <= 32'h0;
    end else if (state == DATA && !lat_err && !lat_wr) begin
      if (lat_core) begin
        core_rdata <= rd_aligned;
      end else begin
        cpu_rdata  <= rd_aligned;
      end
    end
  end

  // Completion pulse: DONE lasts exactly one cycle.
  always_comb begin
    cpu_ack  = (state == DONE) && !lat_core;
    core_ack = (state == DONE) &&  lat_core;
    cpu_err  = cpu_ack  & lat_err;
    core_err = core_ack & lat_err;
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
`timescale 1ns/1ps

module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = 8'h0;
  logic [1:0]  cpu_size = 2'b0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_err;

  logic        core_req = 1'b0, core_wr = 1'b0;
  logic [7:0]  core_addr = 8'h0;
  logic [1:0]  core_size = 2'b0;
  logic [31:0] core_wdata = 32'h0;
  logic [31:0] core_rdata;
  logic        core_ack, core_err;

  logic        rf_en, rf_wr;
  logic [5:0]  rf_addr;
  logic [3:0]  rf_be;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata = 32'h0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr), .core_size(core_size),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err),
    .rf_en(rf_en), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_be(rf_be),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register bank model: word 0x0B preloaded for the byte-read case.
  logic [31:0] mem [64] = '{11: 32'h11223344, default: 32'h0};

  always @(posedge clk) begin
    if (rf_en) begin
      rf_rdata <= mem[rf_addr];
      if (rf_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (rf_be[b]) mem[rf_addr][8*b +: 8] <= rf_wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct packed {
    logic        port;   // 0 = cpu, 1 = core
    logic        err;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rf_exp_t;

  ack_exp_t ack_q[$];
  rf_exp_t  rf_q[$];

  int total = 0;
  int bad = 0;

  logic [31:0] exp_cpu_rdata = 32'h0;
  logic [31:0] exp_core_rdata = 32'h0;

  // Contention phase: scoreboard bypassed, acks counted instead.
  logic sb_off = 1'b0;
  int   cnt_cpu_ack = 0;
  int   cnt_core_ack = 0;
  int   first_port = -1;
  int   second_port = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: one line per completed transaction.
  logic prev_rf_en = 1'b0;
  always @(negedge clk) begin
    if (rf_en) check_val("rf_en_gap", {31'h0, prev_rf_en}, 32'h0);
    prev_rf_en <= rf_en;

    if (rf_en && !sb_off) begin
      if (rf_q.size() == 0) begin
        check_val("unexpected_rf_en", 32'h1, 32'h0);
      end else begin
        rf_exp_t r;
        r = rf_q.pop_front();
        check_val("rf_wr",    {31'h0, rf_wr},  {31'h0, r.wr});
        check_val("rf_addr",  {26'h0, rf_addr}, {26'h0, r.addr});
        check_val("rf_be",    {28'h0, rf_be},  {28'h0, r.be});
        check_val("rf_wdata", rf_wdata, r.wdata);
      end
    end

    if (cpu_ack || core_ack) begin
      if (sb_off) begin
        if (cpu_ack) cnt_cpu_ack++;
        if (core_ack) cnt_core_ack++;
        if (first_port < 0) first_port = core_ack ? 1 : 0;
        else if (second_port < 0) second_port = core_ack ? 1 : 0;
        $display("contention ack cpu=%0b core=%0b", cpu_ack, core_ack);
      end else if (ack_q.size() == 0) begin
        check_val("unexpected_ack", 32'h1, 32'h0);
      end else begin
        ack_exp_t a;
        logic got_err;
        logic [31:0] got_rd;
        a = ack_q.pop_front();
        got_err = core_ack ? core_err : cpu_err;
        got_rd  = core_ack ? core_rdata : cpu_rdata;
        check_val("ack_port", {31'h0, core_ack}, {31'h0, a.port});
        check_val("ack_err",  {31'h0, got_err},  {31'h0, a.err});
        check_val("rdata",    got_rd, a.rdata);
        $display("txn port=%s err=%0b rdata=%h (exp err=%0b rdata=%h)",
                 core_ack ? "core" : "cpu", got_err, got_rd, a.err, a.rdata);
      end
    end
  end

  task automatic drive_port(input logic port, input logic req, input logic wr,
                            input logic [7:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata);
    if (port) begin
      core_req = req; core_wr = wr; core_addr = addr; core_size = size; core_wdata = wdata;
    end else begin
      cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_size = size; cpu_wdata = wdata;
    end
  endtask

  // One access, started from IDLE. rd_exp is the independently known value
  // of a successful read; ignored for writes and rejected accesses.
  task automatic do_access(input logic port, input logic wr, input logic [7:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] rd_exp);
    logic     err;
    rf_exp_t  r;
    ack_exp_t a;
    int       n;
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00);
    r.wr    = wr;
    r.addr  = addr[7:2];
    r.be    = (size == 2'b00) ? (4'b0001 << addr[1:0]) :
              (size == 2'b01) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    r.wdata = wdata << (8 * addr[1:0]);
    if (!err) rf_q.push_back(r);
    if (!err && !wr) begin
      if (port) exp_core_rdata = rd_exp;
      else      exp_cpu_rdata  = rd_exp;
    end
    a.port  = port;
    a.err   = err;
    a.rdata = port ? exp_core_rdata : exp_cpu_rdata;
    ack_q.push_back(a);

    @(negedge clk);
    drive_port(port, 1'b1, wr, addr, size, wdata);
    @(posedge clk);
    @(negedge clk);
    // Dropping req after the grant must not abort the access.
    drive_port(port, 1'b0, 1'b0, 8'hFF, 2'b11, 32'hFFFF_FFFF);
    n = 1;
    while (!(cpu_ack || core_ack) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", n, 3);
    check_val("loser_ack", {31'h0, port ? cpu_ack : core_ack}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rf"}, {26'h0, rf_en, rf_wr, rf_be}, 32'h0);
    check_val({tag, "_rf_addr"}, {26'h0, rf_addr}, 32'h0);
    check_val({tag, "_rf_wdata"}, rf_wdata, 32'h0);
    check_val({tag, "_ack_err"}, {28'h0, cpu_ack, cpu_err, core_ack, core_err}, 32'h0);
    check_val({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check_val({tag, "_core_rdata"}, core_rdata, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    do_access(1'b0, 1'b1, 8'h10, 2'b10, 32'hDEADBEEF, 32'h0);       // cpu word write
    do_access(1'b1, 1'b0, 8'h2E, 2'b00, 32'h0, 32'h00000022);       // core byte read
    do_access(1'b0, 1'b1, 8'h06, 2'b01, 32'h0000ABCD, 32'h0);       // cpu half write
    do_access(1'b0, 1'b0, 8'h06, 2'b01, 32'h0, 32'h0000ABCD);       // cpu half read
    do_access(1'b0, 1'b0, 8'h02, 2'b10, 32'h0, 32'h0);              // misaligned word
    do_access(1'b1, 1'b0, 8'h08, 2'b11, 32'h0, 32'h0);              // illegal size
    do_access(1'b1, 1'b1, 8'h05, 2'b01, 32'h1234, 32'h0);           // misaligned half
    do_access(1'b0, 1'b1, 8'h13, 2'b00, 32'h0000005A, 32'h0);       // cpu byte write lane 3
    do_access(1'b0, 1'b0, 8'h10, 2'b10, 32'h0, 32'h5AADBEEF);       // cpu word read back
    do_access(1'b1, 1'b0, 8'h12, 2'b01, 32'h0, 32'h00005AAD);       // core half read upper

    // Both requests held for 8 cycles.
    @(negedge clk);
    sb_off = 1'b1;
    cpu_req = 1'b1;  cpu_wr = 1'b1;  cpu_addr = 8'h30;  cpu_size = 2'b10;  cpu_wdata = 32'h1;
    core_req = 1'b1; core_wr = 1'b1; core_addr = 8'h34; core_size = 2'b10; core_wdata = 32'h2;
    repeat (8) @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    core_req = 1'b0;
    @(negedge clk);
    sb_off = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    check_val("rr_cpu_acks", cnt_cpu_ack, 1);
    check_val("rr_core_acks", cnt_core_ack, 1);
    check_val("rr_first", first_port, 0);
    check_val("rr_second", second_port, 1);
`else
    check_val("fp_cpu_acks", cnt_cpu_ack, 2);
    check_val("fp_core_acks", cnt_core_ack, 0);
    check_val("fp_first", first_port, 0);
`endif

    // Reset in the DATA cycle of a read: no ack, everything cleared.
    @(negedge clk);
    rf_q.push_back('{wr: 1'b0, addr: 6'h04, be: 4'b1111, wdata: 32'h0});
    drive_port(1'b0, 1'b1, 1'b0, 8'h10, 2'b10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_port(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    exp_cpu_rdata = 32'h0;
    exp_core_rdata = 32'h0;
    repeat (5) @(negedge clk);
    check_val("midreset_no_ack", {31'h0, cpu_ack | core_ack}, 32'h0);

    do_access(1'b0, 1'b0, 8'h10, 2'b10, 32'h0, 32'h5AADBEEF);

    repeat (3) @(negedge clk);
    check_val("ack_q_empty", ack_q.size(), 0);
    check_val("rf_q_empty", rf_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
